hosted_imem_slave: RTL



---
 rtl/hosted_imem_slave.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hosted_imem_slave.sv
// AXI4 burst-read responder backed by a DEPTH x 32 word array with a host preload port.
// Optional macro HOSTED_IMEM_WRAP_EN enables WRAP bursts (arlen 1/3/7/15).
module hosted_imem_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        s_arready,
  input  logic        s_arvalid,
  input  logic [7:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  input  logic [31:0] s_araddr,
  input  logic        s_rready,
  output logic        s_rvalid,
  output logic [7:0]  s_rid,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH) * 33'd4;
`ifdef HOSTED_IMEM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t      state_r, state_next_s;
  logic        arready_r, rvalid_r, rlast_r;
  logic [7:0]  rid_r, len_r, beat_r;
  logic [31:0] rdata_r, addr_r;
  logic [1:0]  rresp_r, burst_r;
  logic [2:0]  size_r;
  logic [31:0] mem [DEPTH];

  logic        ar_hs_s, r_hs_s, load_beat_s, fetch_err_s, load_ok_s;
  logic [31:0] fetch_addr_s;
  logic [2:0]  fetch_size_s;
  logic [1:0]  fetch_burst_s;
  logic [7:0]  fetch_len_s;
  logic [AW-1:0] fetch_idx_s, load_idx_s;

  function automatic logic in_range(input logic [31:0] a);
    in_range = ({1'b0, a - BASE_ADDR} < DEPTH_BYTES);
  endfunction

  function automatic logic beat_err(input logic [31:0] a, input logic [2:0] sz,
                                    input logic [1:0] bt, input logic [7:0] ln);
    logic len_ok;
    len_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
    beat_err = !in_range(a) || (sz != 3'b010) || (bt == 2'b11) ||
               ((bt == 2'b10) && (!WRAP_EN || !len_ok));
  endfunction

  // WRAP keeps the bits above the (len+1)*4 window and wraps the bits inside it
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] bt,
                                            input logic [7:0] ln);
    logic [31:0] mask;
    mask = {22'd0, ln, 2'b11};
    case (bt)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + 32'd4) & mask);
      default: next_addr = a + 32'd4;
    endcase
  endfunction

  assign ar_hs_s     = s_arvalid & arready_r;
  assign r_hs_s      = rvalid_r & s_rready;
  assign fetch_idx_s = AW'((fetch_addr_s - BASE_ADDR) >> 2);
  assign fetch_err_s = beat_err(fetch_addr_s, fetch_size_s, fetch_burst_s, fetch_len_s);
  assign load_idx_s  = AW'((load_addr - BASE_ADDR) >> 2);
  assign load_ok_s   = in_range(load_addr);

  // Next-state logic and selection of the address/attributes of the beat to fetch
  always_comb begin
    state_next_s  = state_r;
    load_beat_s   = 1'b0;
    fetch_addr_s  = addr_r;
    fetch_size_s  = size_r;
    fetch_burst_s = burst_r;
    fetch_len_s   = len_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_next_s  = BURST;
          load_beat_s   = 1'b1;
          fetch_addr_s  = {s_araddr[31:2], 2'b00};
          fetch_size_s  = s_arsize;
          fetch_burst_s = s_arburst;
          fetch_len_s   = s_arlen;
        end else begin
          state_next_s = IDLE;
        end
      end
      BURST: begin
        if (r_hs_s && rlast_r) begin
          state_next_s = IDLE;
        end else if (r_hs_s) begin
          load_beat_s  = 1'b1;
          fetch_addr_s = next_addr(addr_r, burst_r, len_r);
        end else begin
          state_next_s = BURST;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Channel state, beat bookkeeping and registered R-channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= 8'd0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
      beat_r    <= 8'd0;
      len_r     <= 8'd0;
      size_r    <= 3'd0;
      burst_r   <= 2'b00;
      addr_r    <= 32'd0;
    end else begin
      state_r   <= state_next_s;
      arready_r <= (state_next_s == IDLE);
      if (ar_hs_s) begin
        rid_r    <= s_arid;
        len_r    <= s_arlen;
        size_r   <= s_arsize;
        burst_r  <= s_arburst;
        beat_r   <= 8'd0;
        rlast_r  <= (s_arlen == 8'd0);
        rvalid_r <= 1'b1;
      end else if (r_hs_s && rlast_r) begin
        rvalid_r <= 1'b0;
      end else if (r_hs_s) begin
        beat_r  <= beat_r + 8'd1;
        rlast_r <= ((beat_r + 8'd1) == len_r);
      end
      if (load_beat_s) begin
        addr_r  <= fetch_addr_s;
        rdata_r <= fetch_err_s ? 32'd0 : mem[fetch_idx_s];
        rresp_r <= fetch_err_s ? 2'b10 : 2'b00;
      end
    end
  end

  // Host preload; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (load_en && load_ok_s) begin
      mem[load_idx_s] <= load_data;
    end
  end

  assign s_arready = arready_r;
  assign s_rvalid  = rvalid_r;
  assign s_rid     = rid_r;
  assign s_rdata   = rdata_r;
  assign s_rresp   = rresp_r;
  assign s_rlast   = rlast_r;
endmodule
